// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer/flag controller: binary RAM addresses, Gray pointers,
// occupancy, full/empty, almost-full/almost-empty and sticky overflow/underflow.
module fifo_ptr_ctrl #(
  parameter int ADDR_W   = 7,
  parameter int AF_LEVEL = 2**ADDR_W - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_INC,
  input  logic              RD_INC,
  input  logic              CLR_ERR,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic [ADDR_W:0]   WR_GRAY,
  output logic [ADDR_W:0]   RD_GRAY,
  output logic [ADDR_W:0]   COUNT,
  output logic              FULL,
  output logic              EMPTY,
  output logic              ALMOST_FULL,
  output logic              ALMOST_EMPTY,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PW-1:0] AF_C    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_C    = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] nxt_wr, nxt_rd, nxt_cnt;
  logic          wr_acc, rd_acc, wr_err, rd_err;

  // Acceptance is gated by the registered flags, so no input reaches an output.
  always_comb begin
    wr_acc  = WR_INC & ~FULL;
    rd_acc  = RD_INC & ~EMPTY;
    wr_err  = WR_INC & FULL;
    rd_err  = RD_INC & EMPTY;
    nxt_wr  = wr_ptr + PW'(wr_acc);
    nxt_rd  = rd_ptr + PW'(rd_acc);
    nxt_cnt = COUNT + PW'(wr_acc) - PW'(rd_acc);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      WR_GRAY      <= '0;
      RD_GRAY      <= '0;
      COUNT        <= '0;
      FULL         <= 1'b0;
      EMPTY        <= 1'b1;
      ALMOST_FULL  <= 1'b0;
      ALMOST_EMPTY <= 1'b1;
      OVERFLOW     <= 1'b0;
      UNDERFLOW    <= 1'b0;
    end else begin
      wr_ptr       <= nxt_wr;
      rd_ptr       <= nxt_rd;
      WR_GRAY      <= nxt_wr ^ (nxt_wr >> 1);
      RD_GRAY      <= nxt_rd ^ (nxt_rd >> 1);
      COUNT        <= nxt_cnt;
      FULL         <= (nxt_cnt == DEPTH_C);
      EMPTY        <= (nxt_cnt == '0);
      ALMOST_FULL  <= (nxt_cnt >= AF_C);
      ALMOST_EMPTY <= (nxt_cnt <= AE_C);
      // An error raised in the clear cycle survives the clear.
      OVERFLOW     <= CLR_ERR ? wr_err : (OVERFLOW | wr_err);
      UNDERFLOW    <= CLR_ERR ? rd_err : (UNDERFLOW | rd_err);
    end
  end

  assign WR_ADDR = wr_ptr[ADDR_W-1:0];
  assign RD_ADDR = rd_ptr[ADDR_W-1:0];

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed/seeded-random bench for fifo_ptr_ctrl at ADDR_W=3 (depth 8, AF 6, AE 2).
module tb_fifo_ptr_ctrl;

  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RST, WR_INC, RD_INC, CLR_ERR;
  logic [AW-1:0] WR_ADDR, RD_ADDR;
  logic [AW:0]   WR_GRAY, RD_GRAY, COUNT;
  logic          FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;

  int n_chk = 0;
  int n_err = 0;

  fifo_ptr_ctrl #(.ADDR_W(AW), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .CLK(CLK), .RST(RST), .WR_INC(WR_INC), .RD_INC(RD_INC), .CLR_ERR(CLR_ERR),
    .WR_ADDR(WR_ADDR), .RD_ADDR(RD_ADDR), .WR_GRAY(WR_GRAY), .RD_GRAY(RD_GRAY),
    .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL),
    .ALMOST_EMPTY(ALMOST_EMPTY), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  // Apply inputs for one clock, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic w, input logic rd, input logic c);
    RST = r; WR_INC = w; RD_INC = rd; CLR_ERR = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_cnt"},  32'(COUNT), 32'd0);
    chk({tag, "_addr"}, {24'd0, 1'b0, WR_ADDR, 1'b0, RD_ADDR}, 32'd0);
    chk({tag, "_gray"}, {24'd0, WR_GRAY, RD_GRAY}, 32'd0);
    chk({tag, "_flg"},  {26'd0, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW},
        32'b00_0101_00);
  endtask

  logic [AW:0] m_wr, m_rd, m_cnt, pwg, prg;
  logic        m_ov, m_un, w, r, wa, ra;

  initial begin
    // Reset state
    step(1, 0, 0, 0);
    chk_rst("reset");

    // Fill: 8 writes
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 0);
      chk($sformatf("fill%0d_cnt", i),  32'(COUNT), 32'(i));
      chk($sformatf("fill%0d_flg", i), {28'd0, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY},
          {28'd0, (i == 8), 1'b0, (i >= 6), (i <= 2)});
      chk($sformatf("fill%0d_wa", i),   32'(WR_ADDR), 32'(i % 8));
      chk($sformatf("fill%0d_wg", i),   32'(WR_GRAY), 32'(gray(4'(i))));
    end
    chk("full_wgray", 32'(WR_GRAY), 32'b1100);

    // Write into full
    step(0, 1, 0, 0);
    chk("ovf_flag", 32'(OVERFLOW), 32'd1);
    chk("ovf_wa",   32'(WR_ADDR),  32'd0);
    chk("ovf_cnt",  32'(COUNT),    32'd8);
    step(0, 0, 0, 1);
    chk("clr_ovf",  32'(OVERFLOW), 32'd0);
    chk("clr_full", 32'(FULL),     32'd1);

    // Simultaneous write/read while full
    step(0, 1, 1, 0);
    chk("fwr_cnt",  32'(COUNT),    32'd7);
    chk("fwr_ra",   32'(RD_ADDR),  32'd1);
    chk("fwr_wa",   32'(WR_ADDR),  32'd0);
    chk("fwr_full", 32'(FULL),     32'd0);
    chk("fwr_ovf",  32'(OVERFLOW), 32'd1);
    chk("fwr_rg",   32'(RD_GRAY),  32'b0001);

    // Underflow from reset
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("unf_flag", 32'(UNDERFLOW), 32'd1);
    chk("unf_ra",   32'(RD_ADDR),   32'd0);
    chk("unf_emp",  32'(EMPTY),     32'd1);
    step(0, 1, 1, 0);
    chk("ewr_cnt",  32'(COUNT),     32'd1);
    chk("ewr_emp",  32'(EMPTY),     32'd0);
    chk("ewr_addr", {24'd0, 1'b0, WR_ADDR, 1'b0, RD_ADDR}, 32'h10);
    step(0, 0, 1, 1);  // read accepted, clear with no new error
    chk("clr_unf",  32'(UNDERFLOW), 32'd0);
    chk("clr_cnt",  32'(COUNT),     32'd0);
    step(0, 0, 1, 1);  // new error in clear cycle wins
    chk("clr_win",  32'(UNDERFLOW), 32'd1);

    // Random traffic against a pointer model
    step(1, 0, 0, 0);
    m_wr = '0; m_rd = '0; m_cnt = '0; m_ov = 0; m_un = 0;
    for (int i = 0; i < 40; i++) begin
      w  = (i < 20) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r  = (i < 20) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      wa = w & (m_cnt != 4'd8);
      ra = r & (m_cnt != 4'd0);
      m_ov  = m_ov | (w & (m_cnt == 4'd8));
      m_un  = m_un | (r & (m_cnt == 4'd0));
      m_wr  = m_wr + 4'(wa);
      m_rd  = m_rd + 4'(ra);
      m_cnt = m_cnt + 4'(wa) - 4'(ra);
      pwg = WR_GRAY; prg = RD_GRAY;
      step(0, w, r, 0);
      chk($sformatf("rnd%0d_cnt", i), 32'(COUNT), 32'(4'(m_wr - m_rd)));
      chk($sformatf("rnd%0d_gry", i), {24'd0, WR_GRAY, RD_GRAY}, {24'd0, gray(m_wr), gray(m_rd)});
      chk($sformatf("rnd%0d_hop", i), {$countones(pwg ^ WR_GRAY), $countones(prg ^ RD_GRAY)},
          {32'(wa), 32'(ra)});
      chk($sformatf("rnd%0d_flg", i), {28'd0, FULL, EMPTY, OVERFLOW, UNDERFLOW},
          {28'd0, (m_cnt == 4'd8), (m_cnt == 4'd0), m_ov, m_un});
    end

    // Reset mid-stream with a write pending
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    chk("mid_cnt", 32'(COUNT), 32'd5);
    step(1, 1, 0, 0);
    chk_rst("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
